sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 30 +++
 rtl/owner_fifo.sv | 66 ++++++
 rtl/sram_arbiter.sv | 159 +++++++++++++++
 tb/tb_sram_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-master SRAM-like arbiter: master IDs,
// access-size encodings, default outstanding depth and the request payload.
package sram_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned SIZE_W = 2;

    // Master identifiers as stored in the owner FIFO
    localparam logic MST_INST = 1'b0;
    localparam logic MST_DATA = 1'b1;

    // SRAM-like access size encodings
    localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] SIZE_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'b10;

    localparam int unsigned OUTSTANDING_DEFAULT = 2;

    // Request fields carried from the granted master to the slave
    typedef struct packed {
        logic              wr;
        logic [SIZE_W-1:0] size;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/owner_fifo.sv
// Owner FIFO: records which master owns each accepted slave transaction so
// in-order responses can be routed back.
// Ports:
//   clk, reset     clock, async active-high reset
//   i_push/i_push_id  record a newly accepted transaction and its master ID
//   i_pop          retire the head entry (ignored when empty)
//   o_head_id      master ID of the oldest outstanding transaction
//   o_count        number of outstanding entries (sole full/empty source)
module owner_fifo
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = OUTSTANDING_DEFAULT,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_push_id,
    input  logic             i_pop,
    output logic             o_head_id,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;
    logic             w_push;

    // Pointer increment wrapping modulo DEPTH (DEPTH need not be a power of 2)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_pop     = i_pop && (r_count != '0);
    // A same-cycle pop frees the slot, so push is legal even when full
    assign w_push    = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);
    assign o_head_id = r_mem[r_rptr];
    assign o_count   = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_push_id;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master (inst, data) to one-slave SRAM-like arbiter. Data has priority;
// a presented but unaccepted request locks the grant until it is accepted.
// Responses return in acceptance order and are routed by the owner FIFO.
// Ports:
//   clk, reset           clock, async active-high reset
//   inst_* / data_*      master request in, addr_ok/data_ok/rdata out
//   mem_*                shared slave request out, addr_ok/data_ok/rdata in
//   err_q                sticky flag: slave responded with nothing outstanding
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned OUTSTANDING = OUTSTANDING_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [SIZE_W-1:0] inst_size,
    input  logic [STRB_W-1:0] inst_wstrb,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [SIZE_W-1:0] data_size,
    input  logic [STRB_W-1:0] data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [SIZE_W-1:0] mem_size,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              err_q
);

    localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);

    localparam logic [0:0] ST_OPEN   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             r_lock_id;
    logic             w_lock_id_nxt;

    sram_req_t        w_inst_pl;
    sram_req_t        w_data_pl;
    sram_req_t        w_gnt_pl;
    logic             w_gnt_id;
    logic             w_gnt_req;
    logic             w_mem_req;
    logic             w_accept;
    logic             w_resp;
    logic             w_err;
    logic             w_head_id;
    logic [CNT_W-1:0] w_fifo_count;
    logic             w_fifo_full;
    logic             w_fifo_empty;

    assign w_inst_pl = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb,
                         addr: inst_addr, wdata: inst_wdata};
    assign w_data_pl = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                         addr: data_addr, wdata: data_wdata};

    // Grant: the locked owner if any, else data over inst
    always_comb begin
        w_gnt_id = MST_INST;
        if (r_state == ST_LOCKED) begin
            w_gnt_id = r_lock_id;
        end else if (data_req) begin
            w_gnt_id = MST_DATA;
        end
    end

    assign w_gnt_req = (w_gnt_id == MST_DATA) ? data_req : inst_req;
    assign w_gnt_pl  = (w_gnt_id == MST_DATA) ? w_data_pl : w_inst_pl;

    assign w_fifo_full  = (w_fifo_count == CNT_W'(OUTSTANDING));
    assign w_fifo_empty = (w_fifo_count == '0);

    // Full is judged before any same-cycle pop
    assign w_mem_req = !reset && w_gnt_req && !w_fifo_full;
    assign w_accept  = w_mem_req && mem_addr_ok;
    assign w_resp    = !reset && mem_data_ok && !w_fifo_empty;
    assign w_err     = !reset && mem_data_ok && w_fifo_empty;

    assign mem_req   = w_mem_req;
    assign mem_wr    = w_gnt_pl.wr;
    assign mem_size  = w_gnt_pl.size;
    assign mem_wstrb = w_gnt_pl.wstrb;
    assign mem_addr  = w_gnt_pl.addr;
    assign mem_wdata = w_gnt_pl.wdata;

    assign inst_addr_ok = w_accept && (w_gnt_id == MST_INST);
    assign data_addr_ok = w_accept && (w_gnt_id == MST_DATA);

    // Responses are not buffered; only data_ok selects the receiver
    assign inst_data_ok = w_resp && (w_head_id == MST_INST);
    assign data_data_ok = w_resp && (w_head_id == MST_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    // Grant lock state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_OPEN;
            r_lock_id <= MST_INST;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_id <= w_lock_id_nxt;
        end
    end

    // Lock while a presented request waits; release on accept or on req drop
    always_comb begin
        w_state_nxt   = ST_OPEN;
        w_lock_id_nxt = r_lock_id;
        if (w_mem_req && !mem_addr_ok) begin
            w_state_nxt   = ST_LOCKED;
            w_lock_id_nxt = w_gnt_id;
        end
    end

    // Sticky protocol-error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (w_err) begin
            err_q <= 1'b1;
        end
    end

    owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_accept),
        .i_push_id (w_gnt_id),
        .i_pop     (w_resp),
        .o_head_id (w_head_id),
        .o_count   (w_fifo_count)
    );

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios followed by randomized traffic,
// checked every cycle against a queue-based model of the arbitration rules.
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int unsigned OUTS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        err_q;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (updated once per cycle at the falling edge)
    logic q_owner[$];
    logic m_lock     = 1'b0;
    logic m_lock_id  = 1'b0;
    logic m_err      = 1'b0;
    logic m_inst_acc = 1'b0;
    logic m_data_acc = 1'b0;

    sram_arbiter #(.OUTSTANDING(OUTS)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .err_q(err_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inst(input logic req, input logic wr, input logic [31:0] addr);
        inst_req   = req;
        inst_wr    = wr;
        inst_addr  = addr;
        inst_size  = 2'($urandom_range(2, 0));
        inst_wstrb = 4'($urandom);
        inst_wdata = $urandom;
    endtask

    task automatic set_data(input logic req, input logic wr, input logic [31:0] addr);
        data_req   = req;
        data_wr    = wr;
        data_addr  = addr;
        data_size  = 2'($urandom_range(2, 0));
        data_wstrb = 4'($urandom);
        data_wdata = $urandom;
    endtask

    task automatic idle_inputs();
        set_inst(1'b0, 1'b0, 32'h0);
        set_data(1'b0, 1'b0, 32'h0);
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
    endtask

    // Monitor: predicts this cycle's outputs from the model and the inputs
    initial forever begin : monitor
        logic gnt, gnt_req, exp_mreq, hit, head;
        @(negedge clk);
        if (reset) begin
            chk("rst_mem_req", 32'(mem_req), 32'd0);
            chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
            chk("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
            chk("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
            chk("rst_data_data_ok", 32'(data_data_ok), 32'd0);
            chk("rst_err_q", 32'(err_q), 32'd0);
            q_owner.delete();
            m_lock = 1'b0; m_err = 1'b0; m_inst_acc = 1'b0; m_data_acc = 1'b0;
        end else begin
            chk("err_q", 32'(err_q), 32'(m_err));
            gnt      = m_lock ? m_lock_id : (data_req ? MST_DATA : MST_INST);
            gnt_req  = (gnt == MST_DATA) ? data_req : inst_req;
            exp_mreq = gnt_req && (q_owner.size() < OUTS);
            chk("mem_req", 32'(mem_req), 32'(exp_mreq));
            if (exp_mreq) begin
                chk("mem_addr",  mem_addr,  (gnt == MST_DATA) ? data_addr  : inst_addr);
                chk("mem_wdata", mem_wdata, (gnt == MST_DATA) ? data_wdata : inst_wdata);
                chk("mem_ctl", {25'd0, mem_wr, mem_size, mem_wstrb},
                    (gnt == MST_DATA) ? {25'd0, data_wr, data_size, data_wstrb}
                                      : {25'd0, inst_wr, inst_size, inst_wstrb});
            end
            hit = exp_mreq && mem_addr_ok;
            chk("inst_addr_ok", 32'(inst_addr_ok), 32'(hit && gnt == MST_INST));
            chk("data_addr_ok", 32'(data_addr_ok), 32'(hit && gnt == MST_DATA));
            if (mem_data_ok && q_owner.size() > 0) begin
                head = q_owner.pop_front();
                chk("inst_data_ok", 32'(inst_data_ok), 32'(head == MST_INST));
                chk("data_data_ok", 32'(data_data_ok), 32'(head == MST_DATA));
                if (head == MST_INST) chk("inst_rdata", inst_rdata, mem_rdata);
                else                  chk("data_rdata", data_rdata, mem_rdata);
            end else begin
                chk("inst_data_ok_idle", 32'(inst_data_ok), 32'd0);
                chk("data_data_ok_idle", 32'(data_data_ok), 32'd0);
                if (mem_data_ok) m_err = 1'b1;
            end
            if (hit) q_owner.push_back(gnt);
            m_lock = exp_mreq && !mem_addr_ok;
            if (m_lock) m_lock_id = gnt;
            m_inst_acc = hit && gnt == MST_INST;
            m_data_acc = hit && gnt == MST_DATA;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        repeat (2) next_cycle();
        // Requests and a response during reset must be masked
        set_inst(1'b1, 1'b0, 32'h1C00_0000);
        set_data(1'b1, 1'b0, 32'h0000_1000);
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        #1;
        chk("rst_gate_mem_req", 32'(mem_req), 32'd0);
        chk("rst_gate_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
        chk("rst_gate_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        next_cycle();
        reset = 1'b0;
        idle_inputs();

        // Both request: data wins, inst follows
        next_cycle();
        set_inst(1'b1, 1'b0, 32'h1C00_0000);
        set_data(1'b1, 1'b0, 32'h0000_1000);
        mem_addr_ok = 1'b1;
        @(negedge clk);
        chk("prio_mem_addr", mem_addr, 32'h0000_1000);
        chk("prio_data_addr_ok", 32'(data_addr_ok), 32'd1);
        chk("prio_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        next_cycle();
        data_req = 1'b0;
        @(negedge clk);
        chk("prio_inst_second", 32'(inst_addr_ok), 32'd1);
        chk("prio_mem_addr2", mem_addr, 32'h1C00_0000);
        next_cycle();
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        chk("order_data_first", 32'(data_data_ok), 32'd1);
        chk("order_data_rdata", data_rdata, 32'h1111_2222);
        next_cycle();
        mem_rdata = 32'h3333_4444;
        @(negedge clk);
        chk("order_inst_second", 32'(inst_data_ok), 32'd1);
        next_cycle();
        mem_data_ok = 1'b0;

        // Grant lock: inst stalled three cycles while data rises
        set_inst(1'b1, 1'b0, 32'h1C00_0040);
        @(negedge clk);
        chk("lock_c1_addr", mem_addr, 32'h1C00_0040);
        next_cycle();
        set_data(1'b1, 1'b1, 32'h0000_2000);
        @(negedge clk);
        chk("lock_c2_addr", mem_addr, 32'h1C00_0040);
        chk("lock_c2_data_ok", 32'(data_addr_ok), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("lock_c3_addr", mem_addr, 32'h1C00_0040);
        next_cycle();
        mem_addr_ok = 1'b1;
        @(negedge clk);
        chk("lock_accept_inst", 32'(inst_addr_ok), 32'd1);
        next_cycle();
        inst_req = 1'b0;
        @(negedge clk);
        chk("lock_then_data", 32'(data_addr_ok), 32'd1);
        chk("lock_then_addr", mem_addr, 32'h0000_2000);
        next_cycle();
        data_req = 1'b0;

        // FIFO full: third request blocked, then in-order responses
        set_inst(1'b1, 1'b0, 32'h1C00_0080);
        @(negedge clk);
        chk("full_mem_req", 32'(mem_req), 32'd0);
        next_cycle();
        mem_data_ok = 1'b1; mem_rdata = 32'hAAAA_5555;
        @(negedge clk);
        chk("full_inst_data_ok", 32'(inst_data_ok), 32'd1);
        chk("full_inst_rdata", inst_rdata, 32'hAAAA_5555);
        chk("full_pop_gate", 32'(mem_req), 32'd0);
        next_cycle();
        mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("full_data_data_ok", 32'(data_data_ok), 32'd1);
        chk("pushpop_accept", 32'(inst_addr_ok), 32'd1);
        next_cycle();
        inst_req = 1'b0; mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("pushpop_head", 32'(inst_data_ok), 32'd1);
        next_cycle();
        mem_data_ok = 1'b0; mem_addr_ok = 1'b0;

        // Response with nothing outstanding
        mem_data_ok = 1'b1;
        @(negedge clk);
        chk("spurious_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        next_cycle();
        mem_data_ok = 1'b0;
        @(negedge clk);
        chk("spurious_err_q", 32'(err_q), 32'd1);

        // Asynchronous reset with two outstanding
        next_cycle();
        set_inst(1'b1, 1'b0, 32'h1C00_00C0);
        set_data(1'b1, 1'b0, 32'h0000_3000);
        mem_addr_ok = 1'b1;
        next_cycle();
        data_req = 1'b0;
        next_cycle();
        data_req = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h7777_8888;
        #2;
        reset = 1'b1;
        #1;
        chk("async_mem_req", 32'(mem_req), 32'd0);
        chk("async_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
        chk("async_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        chk("async_err_q", 32'(err_q), 32'd0);
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        next_cycle();
        set_inst(1'b1, 1'b0, 32'h1C00_0100);
        mem_addr_ok = 1'b1;
        @(negedge clk);
        chk("post_rst_accept", 32'(inst_addr_ok), 32'd1);
        next_cycle();
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_BABE;
        @(negedge clk);
        chk("post_rst_inst_ok", 32'(inst_data_ok), 32'd1);
        chk("post_rst_rdata", inst_rdata, 32'hCAFE_BABE);
        chk("post_rst_err_q", 32'(err_q), 32'd0);
        next_cycle();
        mem_data_ok = 1'b0;

        // Random traffic; masters hold a request until it is accepted
        for (int c = 0; c < 400; c++) begin
            next_cycle();
            if (!inst_req || m_inst_acc) begin
                if ($urandom_range(1, 0) == 1)
                    set_inst(1'b1, 1'($urandom_range(1, 0)), {8'h1C, 24'($urandom)});
                else
                    inst_req = 1'b0;
            end
            if (!data_req || m_data_acc) begin
                if ($urandom_range(2, 0) == 0)
                    set_data(1'b1, 1'($urandom_range(1, 0)), {8'h00, 24'($urandom)});
                else
                    data_req = 1'b0;
            end
            mem_addr_ok = ($urandom_range(3, 0) != 0);
            mem_data_ok = (q_owner.size() > 0) && ($urandom_range(1, 0) == 1);
            mem_rdata   = $urandom;
        end

        // Drain outstanding responses (bounded)
        next_cycle();
        idle_inputs();
        for (int c = 0; c < 8 && q_owner.size() > 0; c++) begin
            mem_data_ok = 1'b1;
            mem_rdata   = $urandom;
            next_cycle();
        end
        mem_data_ok = 1'b0;
        chk("drain_empty", 32'(q_owner.size()), 32'd0);
        repeat (2) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
